act_tile_sequencer: RTL and testbench
=====================================

# act_tile_sequencer

Control FSM that sequences one activation tile through the activation memory and into the systolic array. It accepts a valid/ready stream of 7-bit activations, generates the memory write addresses and drives `load_mem_done` low during the fill. It then raises `Cal` for exactly the number of cycles the diagonal feed needs, waits out the array pipeline, and reports completion. It sits between the top-level tile scheduler and the activation memory, and gates on the weight pre-load being finished.

## Interface
Parameters:
- `SIZE`, 8: array dimension; tile holds SIZE*SIZE activations.
- `DRAIN_CYCLES`, 8: cycles after the last feed before results are complete; must be ≥1.
- `ADDR_WIDTH`, $clog2(SIZE*SIZE): activation memory address width.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a tile; sampled only in IDLE.
- `act_valid` in 1: input activation beat valid.
- `act_data` in 7: activation value.
- `act_ready` out 1: beat accepted when `act_valid & act_ready`.
- `weight_ready` in 1: weights resident in the array.
- `Activation` out 7: registered write data to the activation memory.
- `Activation_Mem_Address_in` out ADDR_WIDTH: registered write address.
- `load_mem_done` out 1: low means the memory writes every cycle.
- `Cal` out 1: feed enable to the activation memory.
- `busy` out 1: high in any state other than IDLE.
- `tile_done` out 1: one-cycle pulse on DONE.

## Operation
- States: IDLE, LOAD, SETTLE, WAITW, CALC, DRAIN, DONE.
- IDLE: `load_mem_done`=1, `Cal`=0, `act_ready`=0. On `start`, clear the beat counter and go to LOAD.
- LOAD: `load_mem_done`=0, `act_ready`=1.
  - Each accepted beat registers `act_data` into `Activation` and the counter value into `Activation_Mem_Address_in`, then increments the counter.
  - Between beats the outputs hold, so the memory rewrites the same value at the same address. This is harmless and intended.
  - On acceptance of beat SIZE*SIZE-1, `act_ready` drops next cycle and the FSM goes to SETTLE.
- SETTLE: one cycle with `load_mem_done`=0 so the final registered beat is written.
- WAITW: `load_mem_done`=1, `Cal`=0. Stay here until `weight_ready`=1. This cycle also clears the memory's internal feed index.
- CALC: `Cal`=1 for exactly 2*SIZE-1 cycles (feed index 0..2*SIZE-2), counted by a cycle counter.
- DRAIN: `Cal`=0, `load_mem_done`=1 for DRAIN_CYCLES cycles.
- DONE: `tile_done`=1 for one cycle, then go to IDLE.
- `start` is ignored outside IDLE.
- `act_valid` is ignored outside LOAD.
- If `weight_ready` drops during CALC it is ignored; the tile is committed.

## Timing
- Reset (`rst`=0, asynchronous) puts all outputs in their IDLE values:
  - `load_mem_done`=1, `Cal`=0, `act_ready`=0, `busy`=0, `tile_done`=0.
  - `Activation`=0, `Activation_Mem_Address_in`=0.
  - All counters 0.
- Reset mid-LOAD or mid-CALC aborts the tile; memory contents are undefined afterwards.
- All outputs are registered.
- `act_ready` is a state decode: it drops the cycle after the last beat is accepted.
- Minimum latency from `start` to `tile_done`, with continuous `act_valid` and `weight_ready` already high: 1 + SIZE*SIZE + 1 + 1 + (2*SIZE-1) + DRAIN_CYCLES cycles.
- `Cal` never overlaps `load_mem_done`=0.
- There is at least one cycle of `load_mem_done`=1 with `Cal`=0 before every CALC. This guarantees the feed index starts at 0.
- The beat counter is SIZE*SIZE-wide modulo. It never wraps inside a tile because LOAD exits on the last beat.

## Configuration
- `TILE_PERF_EN` defined:
  - Adds output `stall_cycles` (16 bits): counts cycles spent in LOAD with `act_valid`=0 plus cycles spent in WAITW.
  - The counter clears on `start` accepted and saturates at 16'hFFFF.
  - The count is held after DONE until the next `start`.
- `TILE_PERF_EN` undefined: the port and the counter are absent, and there is no other behaviour change.

## Structure
- Shared package:
  - State encoding enum.
  - Activation width constant (7).
  - Derived constants CALC_CYCLES = 2*SIZE-1 and TILE_BEATS = SIZE*SIZE.
- Sub-module `tile_cycle_counter`: loadable down-counter with a zero flag. It is used for CALC and DRAIN and is reloaded on state entry.
- The beat counter stays inline.

## Test plan
- SIZE=8, continuous valid, `weight_ready`=1 → exactly 64 writes at addresses 0..63 carrying `act_data`. `Cal` is high for 15 cycles, and `tile_done` fires 1+64+1+1+15+8 cycles after `start`.
- Random `act_valid` gaps in LOAD → addresses remain strictly sequential, no beat is lost, and the final beat is written during SETTLE.
- `weight_ready` held low for 20 cycles after LOAD → the FSM stays in WAITW with `Cal`=0, and CALC starts the cycle after `weight_ready` rises.
- `start` pulsed during CALC → ignored. A second `start` in IDLE runs a clean second tile, and the feed index restarts at 0 (first column valid only).
- `rst` asserted after beat 30 → all outputs return to reset values immediately. A new tile then restarts at address 0.
- `TILE_PERF_EN` with 5 valid gaps and 3 WAITW cycles → `stall_cycles`=8 at `tile_done`.

Source files
------------

// File: rtl/act_tile_sequencer_pkg.sv
// Shared types and constants for the activation tile sequencer.
// Sizing helpers let modules derive tile constants from their own SIZE parameter.
package act_tile_sequencer_pkg;

  localparam int ACT_WIDTH   = 7;
  localparam int STALL_WIDTH = 16;
  localparam int DEF_SIZE    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_WAITW,
    ST_CALC,
    ST_DRAIN,
    ST_DONE
  } tile_state_e;

  function automatic int calc_cycles(input int size);
    return 2 * size - 1;
  endfunction

  function automatic int tile_beats(input int size);
    return size * size;
  endfunction

  localparam int CALC_CYCLES = calc_cycles(DEF_SIZE);
  localparam int TILE_BEATS  = tile_beats(DEF_SIZE);

endpackage

// File: rtl/act_tile_sequencer_if.sv
// Activation stream and activation-memory write/feed bus of the tile sequencer.
// Stream handshake: a beat transfers on a rising clk edge where act_valid & act_ready are both high.
interface act_tile_sequencer_if
  import act_tile_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
);

  logic                  act_valid;
  logic [ACT_WIDTH-1:0]  act_data;
  logic                  act_ready;

  logic [ACT_WIDTH-1:0]  Activation;
  logic [ADDR_WIDTH-1:0] Activation_Mem_Address_in;
  logic                  load_mem_done;
  logic                  Cal;

  modport master (
    output act_valid, act_data,
    input  act_ready, Activation, Activation_Mem_Address_in, load_mem_done, Cal
  );

  modport slave (
    input  act_valid, act_data,
    output act_ready, Activation, Activation_Mem_Address_in, load_mem_done, Cal
  );

endinterface

// File: rtl/act_tile_sequencer_tile_cycle_counter.sv
// Loadable down-counter with a zero flag; times the CALC and DRAIN phases.
// A load takes priority over counting so a phase can be re-armed on its last cycle.
module tile_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/act_tile_sequencer.sv
// Sequences one activation tile: fill the activation memory, feed the array, drain, report.
// Optional build macro TILE_PERF_EN adds the stall_cycles performance counter.
module act_tile_sequencer
  import act_tile_sequencer_pkg::*;
#(
  parameter int SIZE         = DEF_SIZE,
  parameter int DRAIN_CYCLES = 8,
  parameter int ADDR_WIDTH   = $clog2(SIZE * SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     weight_ready,
  act_tile_sequencer_if.slave      bus,
  output logic                     busy,
  output logic                     tile_done,
`ifdef TILE_PERF_EN
  output logic [STALL_WIDTH-1:0]   stall_cycles,
`endif
  output tile_state_e              fsm_state
);

  localparam int BEATS_N = tile_beats(SIZE);
  localparam int CALC_N  = calc_cycles(SIZE);
  localparam int CNT_MAX = (CALC_N > DRAIN_CYCLES) ? CALC_N : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT  = ADDR_WIDTH'(BEATS_N - 1);
  localparam logic [CNT_W-1:0]      CALC_LOAD  = CNT_W'(CALC_N - 1);
  localparam logic [CNT_W-1:0]      DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  tile_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic                  accept;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_value;
  logic                  cnt_en;
  logic                  cnt_zero;

  // act_ready is high exactly in LOAD, so it alone qualifies a transfer.
  assign accept    = bus.act_ready & bus.act_valid;
  assign cnt_en    = (state_q == ST_CALC) || (state_q == ST_DRAIN);
  assign fsm_state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   if (accept && (beat_cnt == LAST_BEAT)) state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAITW;
      ST_WAITW: begin
        if (weight_ready) begin
          state_d   = ST_CALC;
          cnt_load  = 1'b1;
          cnt_value = CALC_LOAD;
        end
      end
      ST_CALC: begin
        if (cnt_zero) begin
          state_d   = ST_DRAIN;
          cnt_load  = 1'b1;
          cnt_value = DRAIN_LOAD;
        end
      end
      ST_DRAIN:  if (cnt_zero) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state, so they track state_q exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= ST_IDLE;
      bus.act_ready     <= 1'b0;
      bus.load_mem_done <= 1'b1;
      bus.Cal           <= 1'b0;
      busy              <= 1'b0;
      tile_done         <= 1'b0;
    end else begin
      state_q           <= state_d;
      bus.act_ready     <= (state_d == ST_LOAD);
      bus.load_mem_done <= !((state_d == ST_LOAD) || (state_d == ST_SETTLE));
      bus.Cal           <= (state_d == ST_CALC);
      busy              <= (state_d != ST_IDLE);
      tile_done         <= (state_d == ST_DONE);
    end
  end

  // Write data/address hold between beats; rewriting the same word is harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt                      <= '0;
      bus.Activation                <= '0;
      bus.Activation_Mem_Address_in <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      beat_cnt <= '0;
    end else if (accept) begin
      bus.Activation                <= bus.act_data;
      bus.Activation_Mem_Address_in <= beat_cnt;
      beat_cnt                      <= beat_cnt + 1'b1;
    end
  end

  tile_cycle_counter #(
    .WIDTH(CNT_W)
  ) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(cnt_value),
    .en        (cnt_en),
    .zero      (cnt_zero)
  );

`ifdef TILE_PERF_EN
  logic stall_now;

  assign stall_now = ((state_q == ST_LOAD) && !bus.act_valid) || (state_q == ST_WAITW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      stall_cycles <= '0;
    end else if (stall_now && (stall_cycles != {STALL_WIDTH{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_act_tile_sequencer.sv
// Directed bench for act_tile_sequencer: fill, gaps, weight wait, start-in-CALC, mid-load reset.
// Define TILE_PERF_EN for both bench and RTL to also check stall_cycles.
module tb_act_tile_sequencer;
  import act_tile_sequencer_pkg::*;

  localparam int SIZE    = 8;
  localparam int DRAIN   = 8;
  localparam int AW      = 6;
  localparam int BEATS   = SIZE * SIZE;
  localparam int CALC_N  = 2 * SIZE - 1;
  localparam int MIN_LAT = 1 + BEATS + 1 + 1 + CALC_N + DRAIN;
  localparam int BOUND   = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        weight_ready = 1'b0;
  logic        busy;
  logic        tile_done;
  tile_state_e fsm_state;
`ifdef TILE_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;
  logic [AW+6:0] exp_q[$];

  act_tile_sequencer_if #(.ADDR_WIDTH(AW)) bus();

  act_tile_sequencer #(
    .SIZE        (SIZE),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .weight_ready(weight_ready),
    .bus         (bus),
    .busy        (busy),
    .tile_done   (tile_done),
`ifdef TILE_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq(tag, {busy, tile_done, bus.load_mem_done, bus.Cal, bus.act_ready}, 5'b00100);
    check_eq({tag, "_data"}, bus.Activation, 0);
    check_eq({tag, "_addr"}, bus.Activation_Mem_Address_in, 0);
    check_eq({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  // Runs one full tile from IDLE; all timing is relative to the start edge.
  task automatic run_tile(input int tile_id, input int n_gaps, input int w_hold,
                          input bit start_in_calc, input int exp_stall);
    int cyc = 0, beat = 0, gaps = 0, k = 0, cal_cnt = 0, fidx = 99, exp_lat;
    bit pend = 0, vld, done_seen = 0;
    logic [6:0] d;
    logic [AW+6:0] exp_w;
    exp_lat = MIN_LAT + n_gaps + ((w_hold > 0) ? w_hold - 1 : 0);
    weight_ready = (w_hold == 0);
    exp_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check_eq("busy_after_start", busy, 1);
`ifdef TILE_PERF_EN
    check_eq("stall_clear", stall_cycles, 0);
`endif
    while (cyc < BOUND) begin
      if (pend) begin
        exp_w = exp_q.pop_front();
        check_eq("mem_write", {bus.Activation_Mem_Address_in, bus.Activation}, exp_w);
        check_eq("write_enable", bus.load_mem_done, 0);
        pend = 0;
      end
      if (beat == BEATS) break;
      vld = !((gaps < n_gaps) && ((cyc % 7) == 3));
      if (!vld) gaps++;
      d = 7'((beat * 3 + tile_id * 17) % 128);
      bus.act_valid = vld;
      bus.act_data  = vld ? d : 7'h55;
      if (vld && bus.act_ready) begin
        exp_q.push_back({AW'(beat), d});
        pend = 1;
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.act_valid = 1'b0;
    check_eq("beats_loaded", beat, BEATS);
    check_eq("ready_drop", bus.act_ready, 0);
    check_eq("settle_state", fsm_state, ST_SETTLE);
    while (cyc < BOUND) begin
      start = 1'b0;
      if ((w_hold > 0) && (k >= 1) && (k <= w_hold)) begin
        check_eq("waitw_hold", {fsm_state, bus.Cal, bus.load_mem_done}, {ST_WAITW, 1'b0, 1'b1});
        if (k == w_hold) weight_ready = 1'b1;
      end
      if ((w_hold > 0) && (k == w_hold + 1)) check_eq("calc_start", bus.Cal, 1);
      if (bus.Cal) begin
        if (cal_cnt == 0) check_eq("feed_idx_start", fidx, 0);
        check_eq("cal_vs_load", bus.load_mem_done, 1);
        fidx++;
        cal_cnt++;
        if (start_in_calc && (cal_cnt == 3)) start = 1'b1;
      end else if (bus.load_mem_done) begin
        fidx = 0;
      end
      if (tile_done) begin
        done_seen = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      k++;
    end
    start = 1'b0;
    check_eq("tile_done_seen", done_seen, 1);
    check_eq("latency", cyc, exp_lat);
    check_eq("cal_cycles", cal_cnt, CALC_N);
`ifdef TILE_PERF_EN
    check_eq("stall_cycles", stall_cycles, exp_stall);
`endif
    @(posedge clk); #1;
    check_eq("done_pulse", {busy, tile_done, bus.load_mem_done, bus.Cal, bus.act_ready}, 5'b00100);
`ifdef TILE_PERF_EN
    check_eq("stall_hold", stall_cycles, exp_stall);
`else
    if (exp_stall < 0) check_eq("stall_arg", exp_stall, 0);
`endif
  endtask

  initial begin
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("idle_after_reset");

    run_tile(1, 0, 0, 1'b0, 1);
    run_tile(2, 5, 20, 1'b0, 25);
    run_tile(3, 0, 0, 1'b1, 1);
    run_tile(4, 0, 0, 1'b0, 1);
    run_tile(6, 5, 3, 1'b0, 8);

    // Abort a tile right after beat 30 is registered.
    weight_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      bus.act_valid = 1'b1;
      bus.act_data  = 7'(i + 64);
      @(posedge clk); #1;
    end
    check_eq("pre_reset_addr", bus.Activation_Mem_Address_in, 30);
    check_eq("pre_reset_data", bus.Activation, 94);
    rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    bus.act_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_tile(7, 0, 0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
